// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and fault codes for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_e;

    // Illegal encodings win over misalignment; access size comes from funct3[1:0].
    function automatic logic [1:0] lsu_fault(input logic is_store, input logic [2:0] funct3,
                                             input logic [2:0] offset);
        logic illegal;
        logic misalign;
        illegal = is_store ? funct3[2] : (funct3 == 3'b111);
        case (funct3[1:0])
            2'd1:    misalign = offset[0];
            2'd2:    misalign = |offset[1:0];
            2'd3:    misalign = |offset;
            default: misalign = 1'b0;
        endcase
        if (illegal)
            return FAULT_ILLEGAL;
        else if (misalign)
            return FAULT_MISALIGN;
        else
            return FAULT_NONE;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extract/extend for loads and lane merge for narrow stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] rd_data,
    input  logic [63:0] wr_data,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] size_mask;

    assign shamt = {offset, 3'b000};
    assign lane  = rd_data >> shamt;

    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    always_comb begin
        load_data = lane;
        case (funct3)
            F3_B:    load_data = {{56{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            F3_BU:   load_data = {56'd0, lane[7:0]};
            F3_HU:   load_data = {48'd0, lane[15:0]};
            F3_WU:   load_data = {32'd0, lane[31:0]};
            default: load_data = lane;
        endcase
    end

    // Keep the untouched lanes of the old doubleword, drop in the new low bytes.
    assign store_data = (rd_data & ~(size_mask << shamt)) | ((wr_data & size_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: request FSM, read-latency counter and response registers
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = 3;

    lsu_state_e        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        fault_q;

    logic [1:0]        req_fault;
    logic              accept;
    logic              rd_done;
    logic              req_is_sd;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] store_merged;

    assign req_fault = lsu_fault(req_is_store, req_funct3, req_addr[2:0]);
    assign req_is_sd = req_is_store && (req_funct3 == F3_D);
    assign accept    = req_valid && (state == IDLE);
    assign rd_done   = (state == RD) && (cnt == CNT_W'(MEM_RD_LAT));

    lsu_lane_align u_lane_align (
        .funct3     (funct3_q),
        .offset     (off_q),
        .rd_data    (mem_rdata),
        .wr_data    (wdata_q),
        .load_data  (load_ext),
        .store_data (store_merged)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault != FAULT_NONE)
                        state_n = RESP;
                    else if (req_is_sd)
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD: begin
                if (rd_done)
                    state_n = is_store_q ? WR : RESP;
            end
            WR: begin
                mem_wr  = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Response fields only show through while the response is being offered.
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_fault = resp_valid ? fault_q : FAULT_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 3'd0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= FAULT_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (accept) begin
            cnt        <= '0;
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[2:0];
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            fault_q    <= req_fault;
            if (req_fault == FAULT_NONE) begin
                mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                if (req_is_sd)
                    mem_wdata <= req_wdata;
            end
        end else if (state == RD) begin
            if (rd_done) begin
                if (is_store_q)
                    mem_wdata <= store_merged;
                else
                    rdata_q <= load_ext;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench: directed table, corner sequences, random vs reference model
module tb_load_store_unit;

    localparam int LAT = 1;
    localparam logic [63:0] BASE = 64'h8877_6655_4433_2211;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;

    load_store_unit #(.ADDR_W(64), .DATA_W(64), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory fixture with LAT-cycle read pipeline
    logic [63:0] mem [0:31];
    logic [63:0] rd_pipe [0:LAT-1];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [63:0] pre_val = 64'd0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_wr) mem[mem_addr[7:3]] <= mem_wdata;
        rd_pipe[0] <= mem[mem_addr[7:3]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    int wr_total = 0;
    int wr_cyc = 0;
    always @(negedge clk) if (mem_wr) begin wr_total++; wr_cyc = cyc; end

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] ref_mem [0:31];
    logic [63:0] last_addr = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = 5'(idx); pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    function automatic logic [1:0] m_fault(input logic st, input logic [2:0] f3, input logic [63:0] addr);
        int size;
        size = 1 << f3[1:0];
        if (st ? (f3 > 3'd3) : (f3 == 3'd7)) return 2'd2;
        if ((int'(addr[2:0]) % size) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] dw, input logic [2:0] f3, input logic [63:0] addr);
        int size, off;
        logic [63:0] v;
        size = 1 << f3[1:0];
        off = int'(addr[2:0]);
        v = 64'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = dw[8*(off+i) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1])
            for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] m_store(input logic [63:0] dw, input logic [2:0] f3, input logic [63:0] addr,
                                            input logic [63:0] wd);
        int size, off;
        size = 1 << f3[1:0];
        off = int'(addr[2:0]);
        for (int i = 0; i < size; i++) dw[8*(off+i) +: 8] = wd[8*i +: 8];
        return dw;
    endfunction

    task automatic run_one(input string tag, input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input int hold, input logic [63:0] exp_rd, input logic [1:0] exp_flt,
                           input int exp_lat, input int exp_wrs, input int exp_wr_lat, input logic [63:0] exp_mem);
        int t0, w0, guard;
        logic [63:0] rd;
        logic [1:0] flt;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        t0 = cyc; w0 = wr_total;
        @(negedge clk);
        req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = {32'd0, $urandom}; req_wdata = {$urandom, $urandom};
        guard = 0;
        while (!resp_valid && guard < 50) begin @(negedge clk); guard++; end
        chk({tag, " resp timeout"}, 64'(resp_valid), 64'd1);
        rd = resp_rdata; flt = resp_fault;
        chk({tag, " latency"}, 64'(cyc - t0), 64'(exp_lat));
        if (exp_flt == 2'd0) last_addr = {addr[63:3], 3'b000};
        chk({tag, " mem_addr"}, mem_addr, last_addr);
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " fault"}, 64'(flt), 64'(exp_flt));
        chk({tag, " wr count"}, 64'(wr_total - w0), 64'(exp_wrs));
        if (exp_wrs > 0) chk({tag, " wr cycle"}, 64'(wr_cyc - t0), 64'(exp_wr_lat));
        chk({tag, " mem word"}, mem[addr[7:3]], exp_mem);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic [1:0]  exp_flt;
        int          exp_lat;
        int          exp_wrs;
        int          exp_wr_lat;
        logic [63:0] exp_mem;
    } vec_t;

    vec_t vtab [17];

    initial begin
        int t0, w0, guard;
        vtab[0]  = '{1'b0, 3'd3, 64'h10, 64'h0, BASE, 2'd0, 3, 0, 0, BASE};
        vtab[1]  = '{1'b0, 3'd0, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 2'd0, 3, 0, 0, BASE};
        vtab[2]  = '{1'b0, 3'd4, 64'h17, 64'h0, 64'h0000_0000_0000_0088, 2'd0, 3, 0, 0, BASE};
        vtab[3]  = '{1'b0, 3'd1, 64'h12, 64'h0, 64'h0000_0000_0000_4433, 2'd0, 3, 0, 0, BASE};
        vtab[4]  = '{1'b0, 3'd2, 64'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, 2'd0, 3, 0, 0, BASE};
        vtab[5]  = '{1'b1, 3'd1, 64'h12, 64'h1234_5678_ABCD, 64'h0, 2'd0, 4, 1, 3, 64'h8877_6655_ABCD_2211};
        vtab[6]  = '{1'b0, 3'd2, 64'h16, 64'h0, 64'h0, 2'd1, 1, 0, 0, BASE};
        vtab[7]  = '{1'b0, 3'd7, 64'h16, 64'h0, 64'h0, 2'd2, 1, 0, 0, BASE};
        vtab[8]  = '{1'b1, 3'd3, 64'h08, 64'h0123_4567_89AB_CDEF, 64'h0, 2'd0, 2, 1, 1, 64'h0123_4567_89AB_CDEF};
        vtab[9]  = '{1'b0, 3'd5, 64'h16, 64'h0, 64'h0000_0000_0000_8877, 2'd0, 3, 0, 0, BASE};
        vtab[10] = '{1'b0, 3'd1, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 2'd0, 3, 0, 0, BASE};
        vtab[11] = '{1'b0, 3'd6, 64'h14, 64'h0, 64'h0000_0000_8877_6655, 2'd0, 3, 0, 0, BASE};
        vtab[12] = '{1'b1, 3'd0, 64'h11, 64'hEE, 64'h0, 2'd0, 4, 1, 3, 64'h8877_6655_4433_EE11};
        vtab[13] = '{1'b1, 3'd4, 64'h10, 64'h55, 64'h0, 2'd2, 1, 0, 0, BASE};
        vtab[14] = '{1'b1, 3'd2, 64'h14, 64'hDEAD_BEEF, 64'h0, 2'd0, 4, 1, 3, 64'hDEAD_BEEF_4433_2211};
        vtab[15] = '{1'b1, 3'd1, 64'h13, 64'hFFFF, 64'h0, 2'd1, 1, 0, 0, BASE};
        vtab[16] = '{1'b0, 3'd3, 64'h0C, 64'h0, 64'h0, 2'd1, 1, 0, 0, 64'h0};

        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_fault", 64'(resp_fault), 64'd0);
        chk("reset mem_wr", 64'(mem_wr), 64'd0);
        chk("reset mem_addr", mem_addr, 64'd0);
        chk("reset mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            preload(1, 64'd0);
            preload(2, BASE);
            run_one($sformatf("vec%0d", i), vtab[i].st, vtab[i].f3, vtab[i].addr, vtab[i].wd, i % 3,
                    vtab[i].exp_rd, vtab[i].exp_flt, vtab[i].exp_lat, vtab[i].exp_wrs,
                    vtab[i].exp_wr_lat, vtab[i].exp_mem);
        end

        // Response held off for five cycles while another request waits
        preload(1, 64'd0);
        preload(2, BASE);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd3; req_addr = 64'h10; t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("hold latency", 64'(cyc - t0), 64'd3);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd3; req_addr = 64'h08;
        req_wdata = 64'hCAFE_F00D_1234_5678; w0 = wr_total;
        for (int k = 0; k < 5; k++) begin
            chk("hold resp_valid", 64'(resp_valid), 64'd1);
            chk("hold resp_rdata", resp_rdata, BASE);
            chk("hold resp_fault", 64'(resp_fault), 64'd0);
            chk("hold req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after handshake req_ready", 64'(req_ready), 64'd1);
        chk("after handshake resp_valid", 64'(resp_valid), 64'd0);
        chk("held request not written", 64'(wr_total - w0), 64'd0);
        t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("queued SD latency", 64'(cyc - t0), 64'd2);
        chk("queued SD wr count", 64'(wr_total - w0), 64'd1);
        chk("queued SD mem_addr", mem_addr, 64'h08);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("queued SD mem word", mem[1], 64'hCAFE_F00D_1234_5678);
        ref_mem[1] = 64'hCAFE_F00D_1234_5678;

        // Reset while a narrow store is still reading
        preload(2, BASE);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 64'h11; req_wdata = 64'hEE;
        w0 = wr_total;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midreset req_ready", 64'(req_ready), 64'd1);
        chk("midreset resp_valid", 64'(resp_valid), 64'd0);
        chk("midreset resp_rdata", resp_rdata, 64'd0);
        chk("midreset mem_wr", 64'(mem_wr), 64'd0);
        chk("midreset mem_addr", mem_addr, 64'd0);
        chk("midreset mem_wdata", mem_wdata, 64'd0);
        rst = 1'b0;
        last_addr = 64'd0;
        repeat (6) @(negedge clk);
        chk("midreset no write", 64'(wr_total - w0), 64'd0);
        chk("midreset mem word", mem[2], BASE);

        // Random requests against the reference model
        for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
        for (int n = 0; n < 150; n++) begin
            logic st;
            logic [2:0] f3;
            logic [63:0] addr, wd, e_rd, e_mem;
            logic [1:0] e_flt;
            int idx, off, size, e_lat, e_wrs, e_wl;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            idx = $urandom_range(0, 31);
            size = 1 << f3[1:0];
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off - (off % size);
            addr = 64'(idx * 8 + off);
            wd = {$urandom, $urandom};
            e_flt = m_fault(st, f3, addr);
            e_rd = 64'd0; e_wrs = 0; e_wl = 0;
            if (e_flt != 2'd0) begin
                e_lat = 1;
            end else if (st) begin
                ref_mem[idx] = m_store(ref_mem[idx], f3, addr, wd);
                e_wrs = 1;
                e_lat = (f3 == 3'd3) ? 2 : LAT + 3;
                e_wl = (f3 == 3'd3) ? 1 : LAT + 2;
            end else begin
                e_rd = m_load(ref_mem[idx], f3, addr);
                e_lat = LAT + 2;
            end
            e_mem = ref_mem[idx];
            run_one($sformatf("rnd%0d", n), st, f3, addr, wd, $urandom_range(0, 2),
                    e_rd, e_flt, e_lat, e_wrs, e_wl, e_mem);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
